kamikaze_imem: RTL
==================

// Module: kamikaze_imem
// PURPOSE
//  Instruction-memory responder: the memory end of the core's im_addr/im_data fetch port.
//  Serves 32-bit fetches at any halfword-aligned address, so RV32C fetch needs no core-side realignment.
//  Storage is split into even/odd word banks so a straddling fetch reads both words in one cycle.
//  Holds a LOAD/RUN state machine with a valid/ready loader port for program download.
// PARAMETERS
//  DEPTH_WORDS  1024           number of 32-bit words; power of two, >= 2; AW = log2(DEPTH_WORDS)
//  BASE_ADDR    32'h0000_0000  byte address of word 0; must be 4-byte aligned
//  NOP_INSTR    32'h0000_0013  data returned when the response carries no valid instruction (addi x0,x0,0)
// PORTS
//  clk_i       in   1   clock; all logic is rising-edge
//  rst_i       in   1   reset; asynchronous assert, active-low
//  im_addr_i   in   32  fetch byte address from the core (the core's im_addr_o)
//  im_data_o   out  32  fetched instruction bits (the core's im_data_i); registered
//  im_valid_o  out  1   im_data_o holds a real fetch response
//  im_err_o    out  1   the fetch was misaligned or out of range; im_data_o = NOP_INSTR
//  ld_valid_i  in   1   loader write request
//  ld_ready_o  out  1   loader write accepted this cycle
//  ld_addr_i   in   AW  loader word index
//  ld_data_i   in   32  loader write data
//  ld_done_i   in   1   loader finished; enter RUN
//  ld_req_i    in   1   request return to LOAD from RUN
// BEHAVIOUR
//  Reset (rst_i low, async): state=LOAD; im_data_o=NOP_INSTR; im_valid_o=0; im_err_o=0; ld_ready_o=0.
//   Memory contents are NOT reset and are retained across reset.
//  ld_ready_o is a register: 1 in every LOAD cycle after reset release, 0 in RUN. It is 0 while reset is asserted.
//  LOAD state:
//   - Write mem[ld_addr_i] <= ld_data_i when ld_valid_i & ld_ready_o. Bank select = ld_addr_i[0].
//   - The fetch port is ignored. im_valid_o=0, im_err_o=0, im_data_o=NOP_INSTR.
//   - ld_done_i=1 -> state RUN next cycle. A write presented in the same cycle is still performed.
//  RUN state:
//   - ld_ready_o=0; loader writes are not accepted.
//   - im_addr_i is sampled every cycle; the response appears on im_data_o/im_valid_o/im_err_o at the next edge (latency 1).
//   - im_valid_o rises on the second edge after entering RUN, i.e. with the first response.
//   - off = im_addr_i - BASE_ADDR (32-bit modulo); w = off[AW+1:2]; w1 = (w+1) mod DEPTH_WORDS.
//   - off[0]=1 or off >= 4*DEPTH_WORDS: response is NOP_INSTR with im_err_o=1 and im_valid_o=1.
//   - off[1]=0: im_data_o = mem[w].
//   - off[1]=1: im_data_o = {mem[w1][15:0], mem[w][31:16]}.
//     At the top halfword (w=DEPTH_WORDS-1) w1 wraps to 0; this is legal and raises no error.
//   - ld_req_i=1 -> state LOAD next cycle. The request cycle still produces a normal response.
//     From the following edge: im_valid_o=0, ld_ready_o=1.
//   - ld_done_i is ignored in RUN. ld_req_i is ignored in LOAD.
//  Mid-operation reset: outputs go to reset values immediately; the in-flight fetch or write is dropped.
//   The memory location targeted by the dropped write is undefined; all other words are unchanged.
//  Memory reads are registered through the banks (sync-read RAM inference). Out-of-range checking uses the full 32-bit off.
// TESTING
//  Run with DEPTH_WORDS=16, BASE_ADDR=0.
//  1 Reset, then load w0..3 = 11111111,22222222,33333333,44444444; pulse ld_done_i; fetch 0x4
//    -> next cycle im_data_o=22222222, im_valid_o=1, im_err_o=0.
//  2 mem[0]=AAAABBBB, mem[1]=CCCCDDDD; fetch 0x2 -> im_data_o=DDDDAAAA.
//  3 Wrap: mem[15]=12345678, mem[0]=9ABCDEF0; fetch 0x3E -> im_data_o=DEF01234, im_err_o=0.
//  4 Errors: fetch 0x40 -> 00000013 with im_err_o=1; fetch 0x1 -> 00000013 with im_err_o=1;
//    then fetch 0x0 -> im_err_o clears.
//  5 ld_valid_i & ld_done_i in the same cycle (w5=CAFEBABE) -> RUN next cycle, fetch 0x14 returns CAFEBABE.
//    Then ld_req_i -> im_valid_o=0 and ld_ready_o=1 one cycle later.
//  6 Drop rst_i mid-RUN -> im_valid_o=0 and im_data_o=00000013 without waiting for a clock edge.
//    Release reset and pulse ld_done_i -> fetch 0x0 returns the pre-reset contents.

Source files
------------

// File: rtl/kamikaze_imem.sv
// kamikaze_imem -- instruction-memory responder for the core's fetch port.
//
// Serves 32-bit fetches at any halfword-aligned byte address. Storage is split
// into an even-word bank and an odd-word bank, so a fetch that straddles two
// words reads both halves in the same cycle. A LOAD/RUN state machine with a
// valid/ready loader port handles program download.
//
// Ports:
//   clk_i       clock, rising edge
//   rst_i       asynchronous reset, active-low
//   im_addr_i   fetch byte address from the core
//   im_data_o   fetched instruction (NOP_INSTR when no valid instruction)
//   im_valid_o  im_data_o carries a real fetch response
//   im_err_o    fetch was misaligned or out of range
//   ld_valid_i  loader write request
//   ld_ready_o  loader write accepted this cycle
//   ld_addr_i   loader word index
//   ld_data_i   loader write data
//   ld_done_i   loader finished; enter RUN
//   ld_req_i    request return to LOAD from RUN
module kamikaze_imem #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR   = 32'h0000_0013,
    localparam int         AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [31:0]   im_addr_i,
    output logic [31:0]   im_data_o,
    output logic          im_valid_o,
    output logic          im_err_o,
    input  logic          ld_valid_i,
    output logic          ld_ready_o,
    input  logic [AW-1:0] ld_addr_i,
    input  logic [31:0]   ld_data_i,
    input  logic          ld_done_i,
    input  logic          ld_req_i
);

    // Row index width inside one bank (kept at least 1 bit for DEPTH_WORDS=2).
    localparam int HALF = DEPTH_WORDS / 2;
    localparam int HW   = (AW > 1) ? AW - 1 : 1;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state_q, state_d;
    logic   ld_ready_q, ld_ready_d;
    logic   valid_q, valid_d;
    logic   err_q, err_d;

    logic [31:0] even_mem [HALF];
    logic [31:0] odd_mem  [HALF];
    logic [31:0] even_rd_q, odd_rd_q;
    logic        half_q, odd_first_q;

    logic [31:0]   off;
    logic [AW-1:0] w, w1;
    logic [HW-1:0] even_idx, odd_idx, wr_idx;
    logic          oor, wr_en;
    logic [31:0]   lo_word, hi_word, fetched;

    // Fetch address decode
    assign off = im_addr_i - BASE_ADDR;
    assign w   = off[AW+1:2];
    assign w1  = w + 1'b1;                       // wraps to 0 at the top word
    assign oor = (off >> (AW + 2)) != 32'd0;     // full 32-bit range check

    // An even first word pairs with the odd word in the same row; an odd
    // first word pairs with the even word in the next row.
    assign even_idx = w[0] ? HW'(w1 >> 1) : HW'(w >> 1);
    assign odd_idx  = HW'(w >> 1);

    // ld_ready_q can only be high while in LOAD, so it alone gates writes.
    assign wr_en  = ld_valid_i && ld_ready_q;
    assign wr_idx = HW'(ld_addr_i >> 1);

    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD:    if (ld_done_i) state_d = RUN;
            RUN:     if (ld_req_i)  state_d = LOAD;
            default: state_d = LOAD;
        endcase
        // Ready rises one edge after re-entering LOAD, together with valid falling,
        // and drops on the same edge that enters RUN.
        ld_ready_d = (state_q == LOAD) && (state_d == LOAD);
        valid_d    = (state_q == RUN);
        err_d      = (state_q == RUN) && (off[0] || oor);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= LOAD;
            ld_ready_q <= 1'b0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ld_ready_q <= ld_ready_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

    // Bank storage: synchronous write and synchronous read, no reset.
    always_ff @(posedge clk_i) begin
        if (wr_en && !ld_addr_i[0]) even_mem[wr_idx] <= ld_data_i;
        even_rd_q <= even_mem[even_idx];
    end

    always_ff @(posedge clk_i) begin
        if (wr_en && ld_addr_i[0]) odd_mem[wr_idx] <= ld_data_i;
        odd_rd_q <= odd_mem[odd_idx];
    end

    always_ff @(posedge clk_i) begin
        half_q      <= off[1];
        odd_first_q <= w[0];
    end

    // Response assembly; gating by the reset flops makes reset take effect at once.
    assign lo_word = odd_first_q ? odd_rd_q : even_rd_q;
    assign hi_word = odd_first_q ? even_rd_q : odd_rd_q;
    assign fetched = half_q ? {hi_word[15:0], lo_word[31:16]} : lo_word;

    assign im_data_o  = (valid_q && !err_q) ? fetched : NOP_INSTR;
    assign im_valid_o = valid_q;
    assign im_err_o   = err_q;
    assign ld_ready_o = ld_ready_q;

endmodule
